// File: rtl/sprite_mixer_pkg.sv
// Shared definitions for the sprite compositor: mode encodings and default colours.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sprite_mixer_pkg;

  // Display mode as presented on the mode input and held in the shadow register.
  typedef enum logic [1:0] {
    MODE_INIT = 2'b00,
    MODE_RUN  = 2'b01,
    MODE_BG   = 2'b10,
    MODE_WIN  = 2'b11
  } mode_e;

  localparam logic [11:0] DEF_TRANSP     = 12'h000;
  localparam logic [11:0] DEF_INIT_COLOR = 12'hF00;
  localparam logic [11:0] DEF_WIN_COLOR  = 12'h00F;

  // Cycles from pix_x/pix_y to out_color.
  localparam int PIPE_LAT = 3;

endpackage

// File: rtl/sprite_hit.sv
// One sprite channel: bounding-box hit test and ROM-relative coordinates.
// Latency: 1 cycle (hit flag and relative coordinates are registered).
// Backpressure: none; a new pixel is accepted every cycle.
module sprite_hit
  import sprite_mixer_pkg::*;
#(
  parameter int X_W = 10,
  parameter int Y_W = 9
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en_i,
  input  logic [X_W-1:0] pos_x_i,
  input  logic [Y_W-1:0] pos_y_i,
  input  logic [X_W-1:0] w_i,
  input  logic [Y_W-1:0] h_i,
  input  logic [X_W-1:0] pix_x_i,
  input  logic [Y_W-1:0] pix_y_i,
  output logic           hit_o,
  output logic [X_W-1:0] rel_x_o,
  output logic [Y_W-1:0] rel_y_o
);

  logic [X_W-1:0] rel_x_d, rel_x_q;
  logic [Y_W-1:0] rel_y_d, rel_y_q;
  logic           in_x, in_y;
  logic           hit_d, hit_q;

  // The offset is only compared once pix >= pos, so it never wraps; a sprite
  // running past the right/bottom edge is clipped rather than reappearing at 0.
  always_comb begin
    rel_x_d = pix_x_i - pos_x_i;
    rel_y_d = pix_y_i - pos_y_i;
    in_x    = (pix_x_i >= pos_x_i) && (rel_x_d < w_i);
    in_y    = (pix_y_i >= pos_y_i) && (rel_y_d < h_i);
    hit_d   = en_i && in_x && in_y;
  end

  // Register the ROM address and hit flag; the address is driven even on a miss.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_q   <= 1'b0;
      rel_x_q <= '0;
      rel_y_q <= '0;
    end else begin
      hit_q   <= hit_d;
      rel_x_q <= rel_x_d;
      rel_y_q <= rel_y_d;
    end
  end

  assign hit_o   = hit_q;
  assign rel_x_o = rel_x_q;
  assign rel_y_o = rel_y_q;

endmodule

// File: rtl/sprite_mixer.sv
// N-channel frame-synchronous sprite compositor with player collision reporting.
// Latency: 3 cycles pixel -> out_color; sprite ROM data is expected 2 cycles after the pixel.
// Backpressure: none; one pixel per cycle and the pipeline never stalls.
module sprite_mixer
  import sprite_mixer_pkg::*;
#(
  parameter int                 NUM_SPR    = 4,
  parameter int                 X_W        = 10,
  parameter int                 Y_W        = 9,
  parameter int                 COLOR_W    = 12,
  parameter logic [COLOR_W-1:0] TRANSP     = COLOR_W'(DEF_TRANSP),
  parameter logic [COLOR_W-1:0] INIT_COLOR = COLOR_W'(DEF_INIT_COLOR),
  parameter logic [COLOR_W-1:0] WIN_COLOR  = COLOR_W'(DEF_WIN_COLOR)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       frame_start,
  input  logic [1:0]                 mode,
  input  logic                       pix_valid,
  input  logic [X_W-1:0]             pix_x,
  input  logic [Y_W-1:0]             pix_y,
  input  logic [NUM_SPR-1:0]         spr_en,
  input  logic [NUM_SPR*X_W-1:0]     spr_x,
  input  logic [NUM_SPR*Y_W-1:0]     spr_y,
  input  logic [NUM_SPR*X_W-1:0]     spr_w,
  input  logic [NUM_SPR*Y_W-1:0]     spr_h,
  output logic [NUM_SPR*X_W-1:0]     rel_x,
  output logic [NUM_SPR*Y_W-1:0]     rel_y,
  input  logic [NUM_SPR*COLOR_W-1:0] spr_color,
  input  logic [COLOR_W-1:0]         bg_color,
  output logic                       out_valid,
  output logic [COLOR_W-1:0]         out_color,
  output logic [NUM_SPR-2:0]         collision
);

  // Shadow copies of the per-frame configuration.
  logic [NUM_SPR-1:0]          sh_en_q;
  logic [NUM_SPR-1:0][X_W-1:0] sh_x_q, sh_w_q;
  logic [NUM_SPR-1:0][Y_W-1:0] sh_y_q, sh_h_q;
  mode_e                       sh_mode_q;

  // Pipeline tags travelling with each pixel.
  logic [NUM_SPR-1:0] hit_s1;
  logic               vld_s1_q, vld_s2_q;
  mode_e              mode_s1_q, mode_s2_q;
  logic [NUM_SPR-1:0] hit_s2_q;

  // Stage-2 view of ROM data and resulting decisions.
  logic [NUM_SPR-1:0][COLOR_W-1:0] spr_col;
  logic [NUM_SPR-1:0]              opq;
  logic [COLOR_W-1:0]              out_color_d, out_color_q;
  logic                            out_valid_q;
  logic [NUM_SPR-2:0]              coll_new;
  logic [NUM_SPR-2:0]              coll_acc_q, coll_q;

  assign spr_col = spr_color;

  // Capture geometry and mode only at frame boundaries so a frame never tears;
  // a pixel in the frame_start cycle still sees the previous values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_en_q   <= '0;
      sh_x_q    <= '0;
      sh_y_q    <= '0;
      sh_w_q    <= '0;
      sh_h_q    <= '0;
      sh_mode_q <= MODE_INIT;
    end else if (frame_start) begin
      sh_en_q   <= spr_en;
      sh_x_q    <= spr_x;
      sh_y_q    <= spr_y;
      sh_w_q    <= spr_w;
      sh_h_q    <= spr_h;
      sh_mode_q <= mode_e'(mode);
    end
  end

  // Stage 1: one hit/address unit per sprite channel.
  for (genvar g = 0; g < NUM_SPR; g++) begin : g_hit
    sprite_hit #(
      .X_W (X_W),
      .Y_W (Y_W)
    ) u_hit (
      .clk     (clk),
      .rst     (rst),
      .en_i    (sh_en_q[g]),
      .pos_x_i (sh_x_q[g]),
      .pos_y_i (sh_y_q[g]),
      .w_i     (sh_w_q[g]),
      .h_i     (sh_h_q[g]),
      .pix_x_i (pix_x),
      .pix_y_i (pix_y),
      .hit_o   (hit_s1[g]),
      .rel_x_o (rel_x[g*X_W +: X_W]),
      .rel_y_o (rel_y[g*Y_W +: Y_W])
    );
  end

  // Carry valid, mode and hits alongside the pixel so they meet the ROM data in stage 2;
  // mode travels with the pixel so in-flight pixels finish in the mode they started with.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_s1_q  <= 1'b0;
      mode_s1_q <= MODE_INIT;
      vld_s2_q  <= 1'b0;
      mode_s2_q <= MODE_INIT;
      hit_s2_q  <= '0;
    end else begin
      vld_s1_q  <= pix_valid;
      mode_s1_q <= sh_mode_q;
      vld_s2_q  <= vld_s1_q;
      mode_s2_q <= mode_s1_q;
      hit_s2_q  <= hit_s1;
    end
  end

  // A sprite is opaque at this pixel only if it hits and its texel is not the key colour.
  always_comb begin
    opq = '0;
    for (int i = 0; i < NUM_SPR; i++) begin
      opq[i] = hit_s2_q[i] && (spr_col[i] != TRANSP);
    end
  end

  // Colour select: fills for INIT/WIN, background for BG, lowest-index opaque sprite otherwise.
  always_comb begin
    out_color_d = bg_color;
    case (mode_s2_q)
      MODE_INIT: out_color_d = INIT_COLOR;
      MODE_WIN:  out_color_d = WIN_COLOR;
      MODE_BG:   out_color_d = bg_color;
      MODE_RUN: begin
        for (int i = NUM_SPR - 1; i >= 0; i--) begin
          if (opq[i]) out_color_d = spr_col[i];
        end
      end
      default:   out_color_d = bg_color;
    endcase
  end

  // Player-vs-sprite overlap on the current pixel, counted only while compositing.
  always_comb begin
    coll_new = '0;
    for (int i = 1; i < NUM_SPR; i++) begin
      coll_new[i-1] = vld_s2_q && (mode_s2_q == MODE_RUN) && opq[0] && opq[i];
    end
  end

  // Output register; colour is held across invalid cycles to keep the line stable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_color_q <= '0;
    end else begin
      out_valid_q <= vld_s2_q;
      if (vld_s2_q) out_color_q <= out_color_d;
    end
  end

  // Accumulate overlaps over a frame and publish them at the next frame_start;
  // the pixel retiring in the frame_start cycle still belongs to the closing frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      coll_acc_q <= '0;
      coll_q     <= '0;
    end else if (frame_start) begin
      coll_q     <= coll_acc_q | coll_new;
      coll_acc_q <= '0;
    end else begin
      coll_acc_q <= coll_acc_q | coll_new;
    end
  end

  assign out_valid = out_valid_q;
  assign out_color = out_color_q;
  assign collision = coll_q;

endmodule

// File: tb/tb_sprite_mixer.sv
module tb_sprite_mixer;

  localparam int N  = 4;
  localparam int XW = 10;
  localparam int YW = 9;
  localparam int CW = 12;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            frame_start = 1'b0;
  logic [1:0]      mode = 2'b00;
  logic            pix_valid = 1'b0;
  logic [XW-1:0]   pix_x = '0;
  logic [YW-1:0]   pix_y = '0;
  logic [N-1:0]    spr_en = '0;
  logic [N*XW-1:0] spr_x = '0, spr_w = '0;
  logic [N*YW-1:0] spr_y = '0, spr_h = '0;
  logic [N*XW-1:0] rel_x;
  logic [N*YW-1:0] rel_y;
  logic [N*CW-1:0] spr_color = '0;
  logic [CW-1:0]   bg_color = '0;
  logic            out_valid;
  logic [CW-1:0]   out_color;
  logic [N-2:0]    collision;

  always #5 clk = ~clk;

  sprite_mixer #(
    .NUM_SPR (N),
    .X_W     (XW),
    .Y_W     (YW),
    .COLOR_W (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .mode        (mode),
    .pix_valid   (pix_valid),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .spr_en      (spr_en),
    .spr_x       (spr_x),
    .spr_y       (spr_y),
    .spr_w       (spr_w),
    .spr_h       (spr_h),
    .rel_x       (rel_x),
    .rel_y       (rel_y),
    .spr_color   (spr_color),
    .bg_color    (bg_color),
    .out_valid   (out_valid),
    .out_color   (out_color),
    .collision   (collision)
  );

  int errors = 0;
  int checks = 0;

  // Configuration the bench presents on the inputs.
  int in_en[N], in_x[N], in_y[N], in_w[N], in_h[N];
  int in_mode = 0;
  // Reference copy of what the mixer should have captured at the last frame_start.
  int sh_en[N], sh_x[N], sh_y[N], sh_w[N], sh_h[N];
  int sh_mode = 0;
  // ROM/background data that will be returned for the next pixel presented.
  logic [CW-1:0] nxt_col[N];
  logic [CW-1:0] nxt_bg = '0;

  typedef struct packed {
    logic                v;
    logic [N-1:0]        hit;
    logic [N-1:0][CW-1:0] col;
    logic [CW-1:0]       bg;
    logic [CW-1:0]       exp;
    logic [N-2:0]        nw;
  } rec_t;

  rec_t          q[$];
  logic [N-2:0]  acc = '0;
  logic [N-2:0]  exp_coll = '0;
  logic [CW-1:0] held = '0;
  int            px;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      spr_en[i]          = (in_en[i] != 0);
      spr_x[i*XW +: XW]  = XW'(in_x[i]);
      spr_y[i*YW +: YW]  = YW'(in_y[i]);
      spr_w[i*XW +: XW]  = XW'(in_w[i]);
      spr_h[i*YW +: YW]  = YW'(in_h[i]);
    end
    mode = 2'(in_mode);
  endtask

  task automatic rand_cols();
    for (int i = 0; i < N; i++)
      nxt_col[i] = ($urandom_range(0, 2) == 0) ? '0 : CW'($urandom);
    nxt_bg = CW'($urandom);
  endtask

  // One clock: present a pixel, return ROM data for the pixel two cycles older,
  // then check outputs against the reference.
  task automatic step(input bit v, input int x, input int y, input bit fs);
    rec_t r, f;
    bit   found, have;
    int   erx[N], ery[N];
    drive_inputs();
    r = '0;
    r.v  = v;
    r.bg = nxt_bg;
    for (int i = 0; i < N; i++) begin
      r.col[i] = nxt_col[i];
      r.hit[i] = (sh_en[i] != 0) && (x >= sh_x[i]) && (x < sh_x[i] + sh_w[i]) &&
                 (y >= sh_y[i]) && (y < sh_y[i] + sh_h[i]);
      erx[i] = (x - sh_x[i]) & ((1 << XW) - 1);
      ery[i] = (y - sh_y[i]) & ((1 << YW) - 1);
    end
    case (sh_mode)
      0: r.exp = 12'hF00;
      3: r.exp = 12'h00F;
      2: r.exp = nxt_bg;
      default: begin
        r.exp = nxt_bg;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
          if (!found && r.hit[i] && r.col[i] != '0) begin
            r.exp = r.col[i];
            found = 1'b1;
          end
        end
      end
    endcase
    if (sh_mode == 1 && v) begin
      for (int i = 1; i < N; i++)
        r.nw[i-1] = r.hit[0] && (r.col[0] != '0) && r.hit[i] && (r.col[i] != '0);
    end
    q.push_back(r);
    pix_valid   = v;
    pix_x       = XW'(x);
    pix_y       = YW'(y);
    frame_start = fs;
    have        = (q.size() == 3);
    f           = have ? q[0] : '0;
    spr_color   = f.col;
    bg_color    = f.bg;
    @(posedge clk);
    #1;
    if (fs) begin
      exp_coll = acc | f.nw;
      acc      = '0;
      for (int i = 0; i < N; i++) begin
        sh_en[i] = in_en[i]; sh_x[i] = in_x[i]; sh_y[i] = in_y[i];
        sh_w[i]  = in_w[i];  sh_h[i] = in_h[i];
      end
      sh_mode = in_mode;
    end else begin
      acc = acc | f.nw;
    end
    chk("out_valid", out_valid, f.v);
    if (f.v) held = f.exp;
    chk("out_color", out_color, held);
    chk("collision", collision, exp_coll);
    for (int i = 0; i < N; i++) begin
      chk("rel_x", rel_x[i*XW +: XW], erx[i]);
      chk("rel_y", rel_y[i*YW +: YW], ery[i]);
    end
    if (have) void'(q.pop_front());
  endtask

  task automatic flush();
    repeat (3) step(1'b0, 0, 0, 1'b0);
  endtask

  task automatic pulse_reset();
    pix_valid   = 1'b0;
    frame_start = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("rst_async_valid", out_valid, 0);
    chk("rst_async_coll", collision, 0);
    @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_color", out_color, 0);
    chk("rst_relx", rel_x, 0);
    rst = 1'b1;
    q.delete();
    for (int i = 0; i < N; i++) begin
      sh_en[i] = 0; sh_x[i] = 0; sh_y[i] = 0; sh_w[i] = 0; sh_h[i] = 0;
    end
    sh_mode  = 0;
    acc      = '0;
    exp_coll = '0;
    held     = '0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) nxt_col[i] = '0;
    #3 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", out_valid, 0);
    chk("reset_color", out_color, 0);
    chk("reset_coll", collision, 0);
    chk("reset_relx", rel_x, 0);
    chk("reset_rely", rel_y, 0);
    rst = 1'b1;

    // Before any frame_start the mixer fills with the INIT colour.
    for (int k = 0; k < 10; k++) begin
      rand_cols();
      step(1'b1, k * 7, k, 1'b0);
    end
    flush();

    // Single sprite: addressing, hit and right-edge miss.
    in_mode = 1;
    in_en[1] = 1; in_x[1] = 100; in_y[1] = 50; in_w[1] = 34; in_h[1] = 36;
    step(1'b0, 0, 0, 1'b1);
    rand_cols(); nxt_col[1] = 12'h0F0; nxt_bg = 12'h0AB;
    step(1'b1, 100, 50, 1'b0);
    chk("spr1_relx", rel_x[XW +: XW], 0);
    chk("spr1_rely", rel_y[YW +: YW], 0);
    step(1'b1, 134, 50, 1'b0);
    step(1'b1, 133, 85, 1'b0);
    step(1'b1, 133, 86, 1'b0);
    step(1'b1, 99, 50, 1'b0);
    flush();

    // Transparent player pixel falls through to sprite 2, then opaque player wins.
    in_en[0] = 1; in_x[0] = 190; in_y[0] = 95;  in_w[0] = 20; in_h[0] = 20;
    in_en[2] = 1; in_x[2] = 195; in_y[2] = 98;  in_w[2] = 30; in_h[2] = 30;
    step(1'b0, 0, 0, 1'b1);
    rand_cols(); nxt_col[0] = 12'h000; nxt_col[2] = 12'h888;
    step(1'b1, 200, 100, 1'b0);
    nxt_col[0] = 12'h123;
    step(1'b1, 200, 100, 1'b0);
    step(1'b0, 0, 0, 1'b0);
    chk("fallthru_888", out_color, 12'h888);
    step(1'b0, 0, 0, 1'b0);
    chk("player_123", out_color, 12'h123);
    flush();

    // Right-edge clipping: no wrap into column 2.
    in_en[3] = 1; in_x[3] = 1020; in_y[3] = 0; in_w[3] = 10; in_h[3] = 500;
    step(1'b0, 0, 0, 1'b1);
    chk("coll_s0_s2", collision, 3'b010);
    rand_cols(); nxt_col[3] = 12'h456;
    step(1'b1, 2, 5, 1'b0);
    step(1'b1, 1023, 5, 1'b0);
    step(1'b1, 1019, 5, 1'b0);
    flush();

    // Frame k: player overlaps opaque sprite 1 (sprite 2 transparent there).
    in_x[1] = 195; in_y[1] = 100;
    step(1'b0, 0, 0, 1'b1);
    chk("coll_clear_k", collision, 3'b000);
    rand_cols(); nxt_col[0] = 12'h111; nxt_col[1] = 12'h222; nxt_col[2] = 12'h000;
    step(1'b1, 200, 105, 1'b0);
    flush();
    step(1'b0, 0, 0, 1'b1);
    chk("coll_frame_k", collision, 3'b001);
    rand_cols();
    step(1'b1, 0, 0, 1'b0);
    flush();
    step(1'b0, 0, 0, 1'b1);
    chk("coll_frame_k1", collision, 3'b000);

    // Mid-frame geometry change is ignored until the next frame_start.
    nxt_col[0] = 12'h000; nxt_col[1] = 12'h222; nxt_col[2] = 12'h333; nxt_bg = 12'h0AB;
    in_x[1] = 300;
    step(1'b1, 200, 105, 1'b0);
    step(1'b1, 200, 105, 1'b0);
    flush();
    step(1'b1, 200, 105, 1'b1);
    step(1'b1, 200, 105, 1'b0);
    flush();

    // Mode changes: pixel on the frame_start cycle keeps the old mode.
    in_mode = 3;
    step(1'b1, 200, 105, 1'b1);
    step(1'b1, 200, 105, 1'b0);
    flush();
    in_mode = 2;
    step(1'b1, 200, 105, 1'b1);
    step(1'b1, 200, 105, 1'b0);
    flush();

    // Randomized frames.
    for (int fr = 0; fr < 14; fr++) begin
      for (int i = 0; i < N; i++) begin
        in_en[i] = ($urandom_range(0, 3) != 0);
        in_x[i]  = ($urandom_range(0, 3) == 0) ? $urandom_range(1000, 1023) : $urandom_range(0, 63);
        in_y[i]  = $urandom_range(0, 63);
        in_w[i]  = $urandom_range(0, 40);
        in_h[i]  = $urandom_range(0, 40);
      end
      in_mode = ($urandom_range(0, 9) < 7) ? 1 : $urandom_range(0, 3);
      for (int c = 0; c < 40; c++) begin
        rand_cols();
        if (c == 20) in_x[$urandom_range(0, N - 1)] = $urandom_range(0, 63);
        px = ($urandom_range(0, 3) == 0) ? $urandom_range(990, 1023) : $urandom_range(0, 70);
        step($urandom_range(0, 99) < 85, px, $urandom_range(0, 70), c == 0);
      end
    end
    flush();
    step(1'b0, 0, 0, 1'b1);

    // Reset mid-line discards in-flight pixels and the pending collision.
    for (int i = 0; i < N; i++) in_en[i] = 0;
    in_mode = 1;
    in_en[0] = 1; in_x[0] = 10; in_y[0] = 10; in_w[0] = 8; in_h[0] = 8;
    in_en[1] = 1; in_x[1] = 12; in_y[1] = 12; in_w[1] = 8; in_h[1] = 8;
    step(1'b0, 0, 0, 1'b1);
    nxt_col[0] = 12'h111; nxt_col[1] = 12'h222;
    step(1'b1, 14, 14, 1'b0);
    step(1'b1, 14, 14, 1'b0);
    step(1'b1, 14, 14, 1'b0);
    pulse_reset();
    step(1'b1, 14, 14, 1'b0);
    flush();
    step(1'b0, 0, 0, 1'b1);
    chk("coll_after_reset", collision, 3'b000);
    step(1'b1, 30, 30, 1'b0);
    flush();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
